// File: rtl/spi_reg_bridge.sv
// Purpose : SPI byte-command decoder plus 8-bit register bank with a host-side access port.
// Latency : register write commits on the rx_done edge; tx_byte and hw_rdata are registered (1 cycle).
// Backpressure: none; the SPI slave paces bytes via rx_done, the host port is always ready.
//
// Optional feature macro: SPI_REG_BRIDGE_AUTOINC_EN
//   defined   -> address walks the bank (wrapping) after every data byte of a burst
//   undefined -> address stays on the command address for the whole transaction
//
// Ports:
//   clk, rst            system clock, synchronous active-low reset
//   ss                  SPI slave select (active-low)
//   rx_byte, rx_done    received byte and its one-cycle valid strobe
//   tx_byte             next byte for the SPI slave to shift out
//   hw_addr, hw_we,
//   hw_wdata, hw_rdata  host register access (read data registered)
//   spi_wr, spi_wr_addr one-cycle notification of an SPI register write

module spi_reg_bridge #(
    parameter int          NUM_REGS  = 16,
    parameter int          ADDR_W    = 4,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic [7:0]        rx_byte,
    input  logic              rx_done,
    output logic [7:0]        tx_byte,
    input  logic [ADDR_W-1:0] hw_addr,
    input  logic              hw_we,
    input  logic [7:0]        hw_wdata,
    output logic [7:0]        hw_rdata,
    output logic              spi_wr,
    output logic [ADDR_W-1:0] spi_wr_addr
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        DROP  = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    // Set whenever ss is seen high; a new transaction may only start after
    // ss has been deasserted, so a reset in the middle of a frame never resumes it.
    logic              ss_seen_high;
    logic [7:0]        regs [NUM_REGS];

    logic              cmd_ok;
    logic [ADDR_W-1:0] cmd_addr;
    logic              hw_ok;
    logic              spi_we;

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
`endif

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
`else
        return a;
`endif
    endfunction

    assign cmd_ok   = (int'(rx_byte[6:0]) < NUM_REGS);
    assign cmd_addr = rx_byte[ADDR_W-1:0];
    assign hw_ok    = (int'(hw_addr) < NUM_REGS);
    // A byte arriving while ss is high belongs to no transaction.
    assign spi_we   = (state == WRITE) && rx_done && !ss;

    // Register bank. The SPI write is placed last so it wins a same-address
    // collision with the host port; different addresses both commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            if (hw_we && hw_ok) begin
                regs[hw_addr] <= hw_wdata;
            end
            if (spi_we) begin
                regs[addr] <= rx_byte;
            end
        end
    end

    // Host read port: pre-write value of the current cycle, so a write is
    // visible on hw_rdata one cycle after it commits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hw_rdata <= 8'h00;
        end else begin
            hw_rdata <= hw_ok ? regs[hw_addr] : 8'h00;
        end
    end

    // Transaction FSM with registered tx_byte / spi_wr outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            addr         <= '0;
            tx_byte      <= 8'h00;
            spi_wr       <= 1'b0;
            spi_wr_addr  <= '0;
            ss_seen_high <= 1'b0;
        end else begin
            spi_wr <= 1'b0;
            if (ss) begin
                ss_seen_high <= 1'b1;
                state        <= IDLE;
                tx_byte      <= 8'h00;
            end else begin
                unique case (state)
                    IDLE: begin
                        tx_byte <= 8'h00;
                        if (ss_seen_high) begin
                            ss_seen_high <= 1'b0;
                            state        <= CMD;
                        end
                    end
                    CMD: begin
                        tx_byte <= 8'h00;
                        if (rx_done) begin
                            addr <= cmd_addr;
                            if (!cmd_ok) begin
                                state   <= DROP;
                                tx_byte <= 8'hFF;
                            end else if (rx_byte[7]) begin
                                state <= WRITE;
                            end else begin
                                state   <= READ;
                                tx_byte <= regs[cmd_addr];
                            end
                        end
                    end
                    WRITE: begin
                        tx_byte <= 8'h00;
                        if (rx_done) begin
                            spi_wr      <= 1'b1;
                            spi_wr_addr <= addr;
                            addr        <= next_addr(addr);
                        end
                    end
                    READ: begin
                        // Resampled every cycle so tx_byte tracks writes
                        // committed in the previous cycle.
                        if (rx_done) begin
                            addr    <= next_addr(addr);
                            tx_byte <= regs[next_addr(addr)];
                        end else begin
                            tx_byte <= regs[addr];
                        end
                    end
                    DROP: begin
                        tx_byte <= 8'hFF;
                    end
                    default: begin
                        state   <= IDLE;
                        tx_byte <= 8'h00;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Purpose : self-checking bench for spi_reg_bridge (scoreboard of SPI write events + register model).
// Latency : n/a (bench).
// Backpressure: n/a (bench).

module tb_spi_reg_bridge;

    logic       clk;
    logic       rst;
    logic       ss;
    logic [7:0] rx_byte;
    logic       rx_done;
    logic [7:0] tx_byte;
    logic [3:0] hw_addr;
    logic       hw_we;
    logic [7:0] hw_wdata;
    logic [7:0] hw_rdata;
    logic       spi_wr;
    logic [3:0] spi_wr_addr;

    spi_reg_bridge #(
        .NUM_REGS (16),
        .ADDR_W   (4),
        .RESET_VAL(8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ss         (ss),
        .rx_byte    (rx_byte),
        .rx_done    (rx_done),
        .tx_byte    (tx_byte),
        .hw_addr    (hw_addr),
        .hw_we      (hw_we),
        .hw_wdata   (hw_wdata),
        .hw_rdata   (hw_rdata),
        .spi_wr     (spi_wr),
        .spi_wr_addr(spi_wr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] model [16];
    logic [3:0] exp_wr_q [$];
    logic [3:0] spi_addr;
    logic [3:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every spi_wr pulse must match the oldest expected write address.
    always @(negedge clk) begin
        if (rst && spi_wr) begin
            if (exp_wr_q.size() == 0) begin
                check("spi_wr_spurious", {31'd0, spi_wr}, 32'd0);
            end else begin
                mon_exp = exp_wr_q.pop_front();
                check("spi_wr_addr", {28'd0, spi_wr_addr}, {28'd0, mon_exp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tick();
    endtask

    task automatic spi_begin();
        ss = 1'b0;
        tick();
        tick();
    endtask

    task automatic spi_end();
        ss = 1'b1;
        tick();
        tick();
    endtask

    task automatic advance();
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
        spi_addr = spi_addr + 4'd1;
`endif
    endtask

    task automatic write_cmd(input logic [3:0] a);
        send_byte({4'b1000, a});
        spi_addr = a;
    endtask

    task automatic write_data(input logic [7:0] d);
        exp_wr_q.push_back(spi_addr);
        model[spi_addr] = d;
        send_byte(d);
        advance();
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        hw_addr  = a;
        hw_wdata = d;
        hw_we    = 1'b1;
        tick();
        hw_we    = 1'b0;
        model[a] = d;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a);
        hw_addr = a;
        tick();
        check(tag, {24'd0, hw_rdata}, {24'd0, model[a]});
    endtask

    initial begin
        rst = 1'b0; ss = 1'b1; rx_byte = 8'h00; rx_done = 1'b0;
        hw_addr = 4'd0; hw_we = 1'b0; hw_wdata = 8'h00; spi_addr = 4'd0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        // 1. reset
        tick(); tick();
        check("rst_tx",     {24'd0, tx_byte},  32'h00);
        check("rst_spi_wr", {31'd0, spi_wr},   32'd0);
        check("rst_hw_rd",  {24'd0, hw_rdata}, 32'h00);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) check_reg("rst_reg", 4'(i));

        // 2. single write
        spi_begin();
        check("cmd_tx", {24'd0, tx_byte}, 32'h00);
        write_cmd(4'd3);
        write_data(8'h5A);
        spi_end();
        check_reg("single_wr_reg3", 4'd3);

        // 3. burst write across the wrap point
        spi_begin();
        write_cmd(4'd15);
        write_data(8'h11);
        write_data(8'h22);
        write_data(8'h33);
        spi_end();
        check_reg("burst_reg15", 4'd15);
        check_reg("burst_reg0",  4'd0);
        check_reg("burst_reg1",  4'd1);

        // 4. burst read
        host_write(4'd4, 8'hC4);
        host_write(4'd5, 8'hC5);
        spi_begin();
        send_byte(8'h04);
        check("read_first", {24'd0, tx_byte}, 32'hC4);
        send_byte(8'h00);
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
        check("read_second", {24'd0, tx_byte}, 32'hC5);
`else
        check("read_second", {24'd0, tx_byte}, 32'hC4);
`endif
        spi_end();
        check("read_end_tx", {24'd0, tx_byte}, 32'h00);

        // 5. out-of-range command
        spi_begin();
        send_byte(8'h90);
        check("drop_tx_cmd", {24'd0, tx_byte}, 32'hFF);
        send_byte(8'hAA);
        check("drop_tx_data", {24'd0, tx_byte}, 32'hFF);
        spi_end();
        check("drop_end_tx", {24'd0, tx_byte}, 32'h00);

        // 6a. host/SPI collision on the same address, then on different ones
        spi_begin();
        write_cmd(4'd2);
        hw_addr = 4'd2; hw_wdata = 8'h01; hw_we = 1'b1;
        rx_byte = 8'h02; rx_done = 1'b1;
        exp_wr_q.push_back(spi_addr);
        model[2] = 8'h02;
        tick();
        hw_we = 1'b0; rx_done = 1'b0;
        tick();
        advance();
        hw_addr = 4'd9; hw_wdata = 8'h99; hw_we = 1'b1;
        rx_byte = 8'h44; rx_done = 1'b1;
        exp_wr_q.push_back(spi_addr);
        model[spi_addr] = 8'h44;
        model[9] = 8'h99;
        tick();
        hw_we = 1'b0; rx_done = 1'b0;
        tick();
        advance();
        spi_end();
        check_reg("collide_reg2", 4'd2);
        check_reg("collide_reg9", 4'd9);

        // 6b. rx_done in the same cycle ss rises
        spi_begin();
        write_cmd(4'd6);
        ss = 1'b1; rx_byte = 8'h77; rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        check("ss_rx_tx",     {24'd0, tx_byte}, 32'h00);
        check("ss_rx_spi_wr", {31'd0, spi_wr},  32'd0);
        tick();
        check_reg("ss_rx_reg6", 4'd6);

        // 7. reset mid-transaction with ss held low: no resume
        spi_begin();
        write_cmd(4'd10);
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        send_byte(8'h8B);
        send_byte(8'h55);
        check("rst_mid_tx", {24'd0, tx_byte}, 32'h00);
        check_reg("rst_mid_reg11", 4'd11);
        ss = 1'b1;
        tick();
        spi_begin();
        write_cmd(4'd11);
        write_data(8'h55);
        spi_end();
        check_reg("post_rst_reg11", 4'd11);

        // final sweep of the whole bank against the model
        for (int i = 0; i < 16; i++) check_reg("final_reg", 4'(i));
        check("spi_wr_pending", exp_wr_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
